// File: rtl/dcm_lock_if.sv
// Signal bundle between the lock controller and the DCM / downstream reset logic.
// master is the controller side; slave is the DCM and the reset consumers.
interface dcm_lock_if;
  logic       locked;
  logic       dcm_rst;
  logic       ready;
  logic       lock_lost;
  logic       fail;
  logic [2:0] retry_count;

  modport master (
    input  locked,
    output dcm_rst,
    output ready,
    output lock_lost,
    output fail,
    output retry_count
  );

  modport slave (
    output locked,
    input  dcm_rst,
    input  ready,
    input  lock_lost,
    input  fail,
    input  retry_count
  );
endinterface

// File: rtl/dcm_lock_ctrl.sv
// DCM reset/lock sequencer: pulses DCM reset, waits for a stable lock, retries
// on timeout or lock loss, and latches a sticky fail after too many attempts.
module dcm_lock_ctrl #(
  parameter int RST_PULSE_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 1048576,
  parameter int STABLE_CYCLES    = 1024,
  parameter int MAX_RETRIES      = 7,
  parameter int CNT_W            = 21
) (
  input  logic        fclk,
  input  logic        rst,
  dcm_lock_if.master  dcm,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_PULSE = 3'd0,
    S_WAIT  = 3'd1,
    S_STAB  = 3'd2,
    S_READY = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       MAX_RC       = 3'(MAX_RETRIES);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       rc_n;
  logic             lost_n;
  logic             retry;
  logic             sync1, locked_s;

  assign state_dbg = state;

  // Two-flop synchronizer: locked comes from the DCM's output clock domain.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= dcm.locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    rc_n    = dcm.retry_count;
    lost_n  = 1'b0;
    retry   = 1'b0;
    case (state)
      S_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end
      end
      S_WAIT: begin
        // A lock seen on the final timeout cycle still counts as a lock.
        if (locked_s) begin
          state_n = S_STAB;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry = 1'b1;
        end
      end
      S_STAB: begin
        if (!locked_s) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = S_READY;
          cnt_n   = '0;
          rc_n    = 3'd0;
        end
      end
      S_READY: begin
        cnt_n = '0;
        if (!locked_s) begin
          lost_n = 1'b1;
          retry  = 1'b1;
        end
      end
      S_FAIL: begin
        cnt_n = '0;
      end
      default: begin
        state_n = S_PULSE;
        cnt_n   = '0;
      end
    endcase

    if (retry) begin
      cnt_n = '0;
      if (dcm.retry_count == MAX_RC) begin
        state_n = S_FAIL;
      end else begin
        state_n = S_PULSE;
        rc_n    = (dcm.retry_count == 3'd7) ? 3'd7 : dcm.retry_count + 3'd1;
      end
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state           <= S_PULSE;
      cnt             <= '0;
      dcm.dcm_rst     <= 1'b1;
      dcm.ready       <= 1'b0;
      dcm.lock_lost   <= 1'b0;
      dcm.fail        <= 1'b0;
      dcm.retry_count <= 3'd0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      dcm.dcm_rst     <= (state_n == S_PULSE) || (state_n == S_FAIL);
      dcm.ready       <= (state_n == S_READY);
      dcm.lock_lost   <= lost_n;
      dcm.fail        <= (state_n == S_FAIL);
      dcm.retry_count <= rc_n;
    end
  end

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Bench for dcm_lock_ctrl: countdown-timer reference model checked every cycle,
// directed bring-up/retry/fail scenarios with literal timings, then random lock noise.
module tb_dcm_lock_ctrl;

  localparam int P  = 4;
  localparam int T  = 100;
  localparam int S  = 16;
  localparam int MR = 2;
  localparam int CW = 21;

  localparam int PH_PULSE = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_READY = 3;
  localparam int PH_FAIL  = 4;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic [2:0] state_dbg;

  dcm_lock_if dif();

  dcm_lock_ctrl #(
    .RST_PULSE_CYCLES(P),
    .LOCK_TIMEOUT(T),
    .STABLE_CYCLES(S),
    .MAX_RETRIES(MR),
    .CNT_W(CW)
  ) dut (
    .fclk(fclk),
    .rst(rst_n),
    .dcm(dif.master),
    .state_dbg(state_dbg)
  );

  always #5 fclk = ~fclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: phase plus a countdown of cycles left in that phase.
  int m_phase, m_left, m_rc;
  bit m_s1, m_s2;
  bit m_dcm_rst, m_ready, m_lost, m_fail;

  always @(posedge fclk or negedge rst_n) begin : model
    bit ls;
    bit do_retry;
    if (!rst_n) begin
      m_phase = PH_PULSE; m_left = P; m_rc = 0;
      m_s1 = 0; m_s2 = 0;
      m_dcm_rst = 1; m_ready = 0; m_lost = 0; m_fail = 0;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = dif.locked;
      m_lost = 0;
      do_retry = 0;
      case (m_phase)
        PH_PULSE: begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_WAIT; m_left = T; end
        end
        PH_WAIT: begin
          if (ls) begin m_phase = PH_STAB; m_left = S; end
          else begin
            m_left--;
            if (m_left == 0) do_retry = 1;
          end
        end
        PH_STAB: begin
          if (!ls) begin m_phase = PH_WAIT; m_left = T; end
          else begin
            m_left--;
            if (m_left == 0) begin m_phase = PH_READY; m_rc = 0; end
          end
        end
        PH_READY: begin
          if (!ls) begin m_lost = 1; do_retry = 1; end
        end
        default: ;
      endcase
      if (do_retry) begin
        if (m_rc == MR) m_phase = PH_FAIL;
        else begin
          m_phase = PH_PULSE;
          m_left  = P;
          m_rc    = (m_rc >= 7) ? 7 : m_rc + 1;
        end
      end
      m_dcm_rst = (m_phase == PH_PULSE) || (m_phase == PH_FAIL);
      m_ready   = (m_phase == PH_READY);
      m_fail    = (m_phase == PH_FAIL);
    end
  end

  bit saw_rst, saw_ready;

  always @(negedge fclk) begin
    logic [6:0] act, exp;
    act = {dif.dcm_rst, dif.ready, dif.lock_lost, dif.fail, dif.retry_count};
    exp = {m_dcm_rst, m_ready, m_lost, m_fail, m_rc[2:0]};
    chk("model_cmp {dcm_rst,ready,lost,fail,rc}", 32'(act), 32'(exp));
    if (dif.dcm_rst) saw_rst = 1;
    if (dif.ready)   saw_ready = 1;
  end

  task automatic tick();
    @(posedge fclk);
    #2;
  endtask

  task automatic count_pulse(output int n);
    n = 0;
    while (dif.dcm_rst && n < 50) begin tick(); n++; end
  endtask

  task automatic lock_to_ready(output int lat);
    int n;
    dif.locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!dif.ready && n < 100);
    lat = n - 1;
  endtask

  initial begin
    int n, maxrc;
    rst_n = 1'b0;
    dif.locked = 1'b0;
    repeat (3) tick();
    chk("reset_dcm_rst", 32'(dif.dcm_rst), 32'd1);
    chk("reset_ready", 32'(dif.ready), 32'd0);
    chk("reset_lock_lost", 32'(dif.lock_lost), 32'd0);
    chk("reset_fail", 32'(dif.fail), 32'd0);
    chk("reset_retry_count", 32'(dif.retry_count), 32'd0);

    // Nominal bring-up
    rst_n = 1'b1;
    count_pulse(n);
    chk("nominal_pulse_len", 32'(n), 32'd4);
    repeat (9) tick();
    lock_to_ready(n);
    chk("nominal_ready_lat", 32'(n), 32'd18);
    chk("nominal_rc", 32'(dif.retry_count), 32'd0);
    chk("nominal_fail", 32'(dif.fail), 32'd0);

    // Lock loss while READY
    dif.locked = 1'b0;
    n = 0;
    while (dif.ready && n < 20) begin tick(); n++; end
    chk("loss_ready_fall_lat", 32'(n), 32'd3);
    chk("loss_lock_lost_on_fall", 32'(dif.lock_lost), 32'd1);
    chk("loss_dcm_rst_on_fall", 32'(dif.dcm_rst), 32'd1);
    tick();
    chk("loss_lock_lost_one_cycle", 32'(dif.lock_lost), 32'd0);
    count_pulse(n);
    chk("loss_pulse_len", 32'(n + 1), 32'd4);
    chk("loss_rc", 32'(dif.retry_count), 32'd1);
    repeat (2) tick();
    lock_to_ready(n);
    chk("relock_ready_lat", 32'(n), 32'd18);
    chk("relock_rc", 32'(dif.retry_count), 32'd0);

    // Glitch during STABILIZE
    rst_n = 1'b0; dif.locked = 1'b0;
    tick();
    rst_n = 1'b1;
    count_pulse(n);
    repeat (3) tick();
    saw_rst = 0;
    dif.locked = 1'b1;
    repeat (11) tick();
    dif.locked = 1'b0;
    tick();
    lock_to_ready(n);
    chk("glitch_ready_lat", 32'(n), 32'd18);
    chk("glitch_no_dcm_rst", 32'(saw_rst), 32'd0);
    chk("glitch_rc", 32'(dif.retry_count), 32'd0);

    // Timeout then async reset mid-WAIT_LOCK
    rst_n = 1'b0; dif.locked = 1'b0;
    tick();
    rst_n = 1'b1;
    count_pulse(n);
    n = 0;
    while (!dif.dcm_rst && n < 200) begin tick(); n++; end
    chk("timeout_len", 32'(n), 32'd100);
    chk("timeout_rc", 32'(dif.retry_count), 32'd1);
    count_pulse(n);
    chk("retry_pulse_len", 32'(n), 32'd4);
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_dcm_rst", 32'(dif.dcm_rst), 32'd1);
    chk("async_ready", 32'(dif.ready), 32'd0);
    chk("async_rc", 32'(dif.retry_count), 32'd0);
    tick();
    rst_n = 1'b1;
    count_pulse(n);
    chk("async_restart_pulse_len", 32'(n), 32'd4);

    // Never locks -> FAIL
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0; maxrc = 0;
    while (!dif.fail && n < 500) begin
      tick(); n++;
      if (int'(dif.retry_count) > maxrc) maxrc = int'(dif.retry_count);
    end
    chk("fail_time", 32'(n), 32'd312);
    chk("fail_max_rc", 32'(maxrc), 32'd2);
    chk("fail_dcm_rst", 32'(dif.dcm_rst), 32'd1);
    chk("fail_ready", 32'(dif.ready), 32'd0);

    // FAIL is sticky against lock activity
    saw_ready = 0;
    dif.locked = 1'b1;
    repeat (200) tick();
    chk("sticky_fail", 32'(dif.fail), 32'd1);
    chk("sticky_no_ready", 32'(saw_ready), 32'd0);
    chk("sticky_dcm_rst", 32'(dif.dcm_rst), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sticky_cleared_by_rst", 32'(dif.fail), 32'd0);
    dif.locked = 1'b0;
    tick();

    // Random lock noise, checked against the model every cycle
    for (int ep = 0; ep < 15; ep++) begin
      int cyc;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      cyc = 0;
      while (cyc < 400) begin
        int hold;
        dif.locked = ($urandom_range(0, 2) != 0);
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
        repeat (hold) tick();
        cyc += hold;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
